// File: rtl/hdmi_timing_if.sv
// hdmi_timing_if: sync/valid inputs from the video stream and the measured geometry outputs
interface hdmi_timing_if;
    logic        hsync;
    logic        vsync;
    logic        rgb_valid;
    logic [11:0] h_total;
    logic [11:0] h_active;
    logic [11:0] v_total;
    logic [11:0] v_active;
    logic        frame_done;
    logic        locked;
    logic        no_signal;

    modport master (
        output hsync, vsync, rgb_valid,
        input  h_total, h_active, v_total, v_active, frame_done, locked, no_signal
    );

    modport slave (
        input  hsync, vsync, rgb_valid,
        output h_total, h_active, v_total, v_active, frame_done, locked, no_signal
    );
endinterface

// File: rtl/hdmi_timing.sv
// hdmi_timing: measures line/frame geometry from hsync/vsync/rgb_valid and tracks lock
module hdmi_timing #(
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 65535
) (
    input logic         hdmi_clk,
    input logic         reset,
    hdmi_timing_if.slave bus
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] TO_CAP  = 16'(TIMEOUT);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    state_t      state, state_n;
    logic        hs_prev, vs_prev, hs_fall, vs_fall;
    logic [11:0] cyc, act, line, v_act, w_htot, w_hact;
    logic [11:0] n_vact, n_htot, n_hact;
    logic        have_h, bad, n_bad, act_line, mism, good, same, publish, timeout;
    logic [15:0] idle;
    logic [7:0]  mcnt, mcnt_n;

    function automatic logic [11:0] sat_inc(input logic [11:0] x, input logic en);
        return (en && x != 12'hfff) ? x + 12'd1 : x;
    endfunction

    // A line ending here is the span since the previous hsync edge; its stats are folded
    // into the working frame in the same cycle so a coincident vsync edge publishes them.
    assign hs_fall  = hs_prev & ~bus.hsync;
    assign vs_fall  = vs_prev & ~bus.vsync;
    assign timeout  = !hs_fall && idle == TO_LAST;
    assign act_line = hs_fall && act != 12'd0;
    assign mism     = cyc != w_htot || act != w_hact;
    assign n_bad    = bad | (act_line & have_h & mism);
    assign n_htot   = (act_line && !have_h) ? cyc : w_htot;
    assign n_hact   = (act_line && !have_h) ? act : w_hact;
    assign n_vact   = sat_inc(v_act, act_line);
    assign publish  = vs_fall && !timeout && state != SEARCH;
    assign good     = !n_bad && n_vact != 12'd0;
    assign same     = n_htot == bus.h_total && n_hact == bus.h_active &&
                      line == bus.v_total && n_vact == bus.v_active;
    assign bus.locked = state == LOCKED;

    // Next match count and lock state, decided at each vsync edge or on timeout
    always_comb begin
        mcnt_n  = timeout ? 8'd0 : !publish ? mcnt : !good ? 8'd0 : !same ? 8'd1 :
                  (mcnt >= LOCK_N ? mcnt : mcnt + 8'd1);
        state_n = timeout ? SEARCH : !vs_fall ? state : state == SEARCH ? MEASURE :
                  (mcnt_n >= LOCK_N ? LOCKED : MEASURE);
    end

    // State and match counter registers
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            state <= SEARCH;
            mcnt  <= 8'd0;
        end else begin
            state <= state_n;
            mcnt  <= mcnt_n;
        end
    end

    // Edge detection, per-line cycle/active counters and the hsync idle watchdog
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            hs_prev   <= 1'b1;
            vs_prev   <= 1'b1;
            cyc       <= 12'd0;
            act       <= 12'd0;
            idle      <= 16'd0;
            bus.no_signal <= 1'b0;
        end else begin
            hs_prev   <= bus.hsync;
            vs_prev   <= bus.vsync;
            cyc       <= hs_fall ? 12'd1 : sat_inc(cyc, 1'b1);
            act       <= hs_fall ? {11'd0, bus.rgb_valid} : sat_inc(act, bus.rgb_valid);
            idle      <= hs_fall ? 16'd0 : (idle == TO_CAP ? idle : idle + 16'd1);
            bus.no_signal <= timeout ? 1'b1 : hs_fall ? 1'b0 : bus.no_signal;
        end
    end

    // Working frame accumulation; a vsync edge restarts it, counting a coincident hsync edge as line 1
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            line   <= 12'd0;
            v_act  <= 12'd0;
            bad    <= 1'b0;
            have_h <= 1'b0;
            w_htot <= 12'd0;
            w_hact <= 12'd0;
        end else if (vs_fall) begin
            line   <= {11'd0, hs_fall};
            v_act  <= 12'd0;
            bad    <= 1'b0;
            have_h <= 1'b0;
        end else begin
            line   <= sat_inc(line, hs_fall);
            v_act  <= n_vact;
            bad    <= n_bad;
            have_h <= have_h | act_line;
            w_htot <= n_htot;
            w_hact <= n_hact;
        end
    end

    // Published geometry and the frame_done pulse that accompanies each update
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            bus.h_total    <= 12'd0;
            bus.h_active   <= 12'd0;
            bus.v_total    <= 12'd0;
            bus.v_active   <= 12'd0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= publish;
            if (publish) begin
                bus.h_total  <= n_htot;
                bus.h_active <= n_hact;
                bus.v_total  <= line;
                bus.v_active <= n_vact;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_timing.sv
// tb_hdmi_timing: frame-level table, random frames against a frame model, and corner sequences
module tb_hdmi_timing;
    localparam int TO   = 6000;
    localparam int LOCK = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    hdmi_timing_if bus();

    hdmi_timing #(.LOCK_FRAMES(LOCK), .TIMEOUT(TO)) dut (
        .hdmi_clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ht; int ha; int vt; int va; int lg;
    } geo_t;

    typedef struct {
        int ht; int ha; int vt; int va; int lg;
        int efd; int eht; int eha; int evt; int eva; int elk;
    } row_t;

    int checks = 0;
    int errors = 0;
    int s_fd, s_ht, s_ha, s_vt, s_va, s_lk, s_ns, fdn;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.rgb_valid = 1'b0;
        repeat (n) tick;
    endtask

    // One frame: hsync low 4 cycles per line, vsync low for lines 0-1 (falling with line 0's
    // hsync edge), active lines 3..3+va-1 with ha valid cycles from cycle 6. Line lg is one
    // cycle longer. The first cycle's outputs are snapshotted (publish of the previous frame).
    task automatic send_frame(input int ht, input int ha, input int vt, input int va,
                              input int lg, input int stop);
        int n;
        n = 0;
        fdn = 0;
        for (int l = 0; l < vt; l++) begin
            for (int c = 0; c < ht + (l == lg ? 1 : 0); c++) begin
                bus.hsync = (c >= 4);
                bus.vsync = (l >= 2);
                bus.rgb_valid = (l >= 3 && l < 3 + va && c >= 6 && c < 6 + ha);
                tick;
                if (n == 0) begin
                    s_fd = int'(bus.frame_done);
                    s_ht = int'(bus.h_total);
                    s_ha = int'(bus.h_active);
                    s_vt = int'(bus.v_total);
                    s_va = int'(bus.v_active);
                    s_lk = int'(bus.locked);
                    s_ns = int'(bus.no_signal);
                end
                fdn += int'(bus.frame_done);
                n++;
                if (stop != 0 && n == stop) return;
            end
        end
    endtask

    task automatic chk_outs(input string p, input int fd, input int ht, input int ha,
                            input int vt, input int va, input int lk);
        chk({p, "_fd"}, s_fd, fd);
        chk({p, "_h_total"}, s_ht, ht);
        chk({p, "_h_active"}, s_ha, ha);
        chk({p, "_v_total"}, s_vt, vt);
        chk({p, "_v_active"}, s_va, va);
        chk({p, "_locked"}, s_lk, lk);
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_h_total"}, int'(bus.h_total), 0);
        chk({p, "_h_active"}, int'(bus.h_active), 0);
        chk({p, "_v_total"}, int'(bus.v_total), 0);
        chk({p, "_v_active"}, int'(bus.v_active), 0);
        chk({p, "_frame_done"}, int'(bus.frame_done), 0);
        chk({p, "_locked"}, int'(bus.locked), 0);
        chk({p, "_no_signal"}, int'(bus.no_signal), 0);
    endtask

    function automatic geo_t rand_geo();
        geo_t g;
        g.ht = int'($urandom_range(60, 30));
        g.ha = int'($urandom_range(g.ht - 8, 1));
        g.vt = int'($urandom_range(14, 8));
        g.va = int'($urandom_range(g.vt - 4, 2));
        g.lg = -1;
        return g;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t tbl[11];
        geo_t cur, prv;
        int mc, good, same;
        int p_ht, p_ha, p_vt, p_va;
        tbl[0]  = '{40, 30, 12, 7, -1, 0,  0,  0,  0, 0, 0};
        tbl[1]  = '{40, 30, 12, 7, -1, 1, 40, 30, 12, 7, 0};
        tbl[2]  = '{40, 30, 12, 7, -1, 1, 40, 30, 12, 7, 1};
        tbl[3]  = '{40, 30, 12, 7,  4, 1, 40, 30, 12, 7, 1};
        tbl[4]  = '{40, 30, 12, 7, -1, 1, 40, 30, 12, 7, 0};
        tbl[5]  = '{40, 30, 12, 7, -1, 1, 40, 30, 12, 7, 0};
        tbl[6]  = '{48, 36, 10, 5, -1, 1, 40, 30, 12, 7, 1};
        tbl[7]  = '{48, 36, 10, 5, -1, 1, 48, 36, 10, 5, 0};
        tbl[8]  = '{48, 36, 10, 5, -1, 1, 48, 36, 10, 5, 1};
        tbl[9]  = '{40, 30, 12, 7, -1, 1, 48, 36, 10, 5, 1};
        tbl[10] = '{40, 30, 12, 7, -1, 1, 40, 30, 12, 7, 0};

        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.rgb_valid = 1'b0;
        reset = 1'b1;
        repeat (3) tick;
        chk_zero("reset");
        reset = 1'b0;
        idle(5);

        for (int i = 0; i < 11; i++) begin
            send_frame(tbl[i].ht, tbl[i].ha, tbl[i].vt, tbl[i].va, tbl[i].lg, 0);
            chk_outs($sformatf("row%0d", i), tbl[i].efd, tbl[i].eht, tbl[i].eha,
                     tbl[i].evt, tbl[i].eva, tbl[i].elk);
            chk($sformatf("row%0d_pulses", i), fdn, tbl[i].efd);
        end

        send_frame(40, 30, 12, 7, -1, 200);
        chk("prereset_locked", s_lk, 1);
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.rgb_valid = 1'b0;
        reset = 1'b1;
        tick;
        chk_zero("midreset");
        reset = 1'b0;
        idle(3);

        mc = 0;
        p_ht = 0; p_ha = 0; p_vt = 0; p_va = 0;
        cur = rand_geo();
        prv = cur;
        for (int k = 0; k < 14; k++) begin
            if (k >= 3 && $urandom_range(2, 0) == 0) cur = rand_geo();
            cur.lg = (k >= 3 && $urandom_range(3, 0) == 0) ? int'($urandom_range(2 + cur.va, 4)) : -1;
            send_frame(cur.ht, cur.ha, cur.vt, cur.va, cur.lg, 0);
            if (k == 0) begin
                chk("rnd0_fd", s_fd, 0);
                chk("rnd0_pulses", fdn, 0);
                chk("rnd0_locked", s_lk, 0);
            end else begin
                good = (prv.lg < 0);
                same = (prv.ht == p_ht && prv.ha == p_ha && prv.vt == p_vt && prv.va == p_va);
                mc = !good ? 0 : !same ? 1 : (mc + 1 > LOCK ? LOCK : mc + 1);
                p_ht = prv.ht; p_ha = prv.ha; p_vt = prv.vt; p_va = prv.va;
                chk_outs($sformatf("rnd%0d", k), 1, p_ht, p_ha, p_vt, p_va, mc >= LOCK ? 1 : 0);
                chk($sformatf("rnd%0d_pulses", k), fdn, 1);
            end
            prv = cur;
        end

        send_frame(40, 30, 12, 7, -1, 0);
        send_frame(40, 30, 12, 7, -1, 0);
        send_frame(40, 30, 12, 7, -1, 1);
        chk("pre_timeout_locked", s_lk, 1);
        idle(TO - 10);
        chk("before_timeout_no_signal", int'(bus.no_signal), 0);
        idle(20);
        chk("timeout_no_signal", int'(bus.no_signal), 1);
        chk("timeout_locked", int'(bus.locked), 0);
        chk("timeout_h_total_kept", int'(bus.h_total), 40);
        chk("timeout_v_total_kept", int'(bus.v_total), 12);
        send_frame(40, 30, 12, 7, -1, 0);
        chk("resume_no_signal", s_ns, 0);
        chk("resume_discard_fd", s_fd, 0);
        chk("resume_discard_pulses", fdn, 0);
        send_frame(40, 30, 12, 7, -1, 0);
        chk_outs("resume1", 1, 40, 30, 12, 7, 0);
        send_frame(5000, 100, 5, 1, -1, 0);
        chk_outs("resume2", 1, 40, 30, 12, 7, 1);
        chk("long_lines_no_signal", int'(bus.no_signal), 0);
        send_frame(40, 30, 12, 7, -1, 2);
        chk_outs("saturate", 1, 4095, 100, 5, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
